// File: rtl/dsp_seq_pkg.sv
// Shared opmode codes and FSM state encoding for the DSP48A1 MAC sequencer.
package dsp_seq_pkg;

    localparam logic [7:0] OPM_ZERO  = 8'h00;
    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;
    localparam logic [7:0] OPM_HOLD  = 8'h08;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/opmode_delay.sv
// Opmode shift register that lines the slice's opmode register up with its M register.
module opmode_delay #(
    parameter int OPM_DLY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] opm_in,
    output logic [7:0] opm_out
);

    generate
        if (OPM_DLY == 0) begin : g_pass
            assign opm_out = opm_in;
        end else begin : g_sr
            logic [7:0] sr_p [OPM_DLY];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < OPM_DLY; i++) sr_p[i] <= '0;
                end else begin
                    sr_p[0] <= opm_in;
                    for (int i = 1; i < OPM_DLY; i++) sr_p[i] <= sr_p[i-1];
                end
            end

            assign opm_out = sr_p[OPM_DLY-1];
        end
    endgenerate

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Streams (a, b) pairs into a DSP48A1 slice and captures each N_TAPS-term dot product from P.
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int N_TAPS  = 8,
    parameter int LAT     = 4,
    parameter int OPM_DLY = 2
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [17:0] s_a,
    input  logic [17:0] s_b,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [47:0] m_data,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [7:0]  dsp_opmode,
    output logic        dsp_ce,
    output logic        dsp_rst,
    input  logic [47:0] dsp_p
);

    localparam int CNT_W = $clog2(N_TAPS);
    localparam int DRN_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS - 1);
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(LAT - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DRN_W-1:0]  drn_cnt;
    logic              accept;
    logic [7:0]        opm_issue;

    assign s_ready = (state == ACCUM);
    assign m_valid = (state == HOLD);
    // Gated with RST so the slice sees zeros while reset is held, even though s_ready is 1.
    assign accept  = s_valid & s_ready & ~RST;
    assign dsp_a   = accept ? s_a : '0;
    assign dsp_b   = accept ? s_b : '0;
    assign dsp_ce  = 1'b1;
    assign dsp_rst = RST;

    // A bubble before the first tap zeroes P; a bubble mid-sum freezes it.
    always_comb begin
        opm_issue = OPM_HOLD;
        if (state == ACCUM) begin
            if (accept) opm_issue = (cnt == '0) ? OPM_FIRST : OPM_ACC;
            else        opm_issue = (cnt == '0) ? OPM_ZERO  : OPM_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state   <= ACCUM;
            cnt     <= '0;
            drn_cnt <= '0;
            m_data  <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (cnt == LAST_TAP) begin
                            cnt     <= '0;
                            drn_cnt <= DRN_LOAD;
                            state   <= DRAIN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // The last product reaches P in the cycle the counter hits zero.
                    if (drn_cnt == '0) begin
                        m_data <= dsp_p;
                        state  <= HOLD;
                    end else begin
                        drn_cnt <= drn_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (m_ready) state <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

    opmode_delay #(
        .OPM_DLY (OPM_DLY)
    ) u_opm_dly (
        .clk     (clk),
        .rst     (RST),
        .opm_in  (opm_issue),
        .opm_out (dsp_opmode)
    );

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: two sequencer instances (4 and 8 taps), each driving a behavioural DSP48A1 slice.
module tb_dsp_mac_sequencer;

    localparam int LAT = 4;

    typedef struct packed {
        logic [3:0][17:0] a;
        logic [3:0][17:0] b;
        logic [3:0]       gap;
        logic [47:0]      exp;
    } vec_t;

    logic        clk;
    logic        RST;
    logic        s_valid, s_ready, m_valid, m_ready;
    logic [17:0] s_a, s_b;
    logic [47:0] m_data;
    logic        s_valid8, s_ready8, m_valid8, m_ready8;
    logic [17:0] s_a8, s_b8;
    logic [47:0] m_data8;

    logic [17:0] da [2];
    logic [17:0] db [2];
    logic [7:0]  dop [2];
    logic        dce [2];
    logic        drst [2];

    // Behavioural slice: A/B two register stages, M, opmode register and P.
    logic [17:0] a1 [2];
    logic [17:0] a2 [2];
    logic [17:0] b1 [2];
    logic [17:0] b2 [2];
    logic [35:0] mr [2];
    logic [7:0]  opr [2];
    logic [47:0] pr [2];

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_acc = 0;
    logic        mv_prev = 1'b0;
    logic [47:0] exp_q [$];
    vec_t        tab [4];

    dsp_mac_sequencer #(.N_TAPS(4), .LAT(LAT), .OPM_DLY(2)) u_dut4 (
        .clk(clk), .RST(RST), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .dsp_a(da[0]), .dsp_b(db[0]),
        .dsp_opmode(dop[0]), .dsp_ce(dce[0]), .dsp_rst(drst[0]), .dsp_p(pr[0])
    );

    dsp_mac_sequencer #(.N_TAPS(8), .LAT(LAT), .OPM_DLY(2)) u_dut8 (
        .clk(clk), .RST(RST), .s_valid(s_valid8), .s_ready(s_ready8), .s_a(s_a8), .s_b(s_b8),
        .m_valid(m_valid8), .m_ready(m_ready8), .m_data(m_data8), .dsp_a(da[1]), .dsp_b(db[1]),
        .dsp_opmode(dop[1]), .dsp_ce(dce[1]), .dsp_rst(drst[1]), .dsp_p(pr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (drst[k]) begin
                a1[k] <= '0; a2[k] <= '0; b1[k] <= '0; b2[k] <= '0;
                mr[k] <= '0; opr[k] <= '0; pr[k] <= '0;
            end else if (dce[k]) begin
                a1[k]  <= da[k];
                a2[k]  <= a1[k];
                b1[k]  <= db[k];
                b2[k]  <= b1[k];
                mr[k]  <= 36'(a2[k]) * 36'(b2[k]);
                opr[k] <= dop[k];
                case (opr[k])
                    8'h00:   pr[k] <= '0;
                    8'h01:   pr[k] <= 48'(mr[k]);
                    8'h09:   pr[k] <= pr[k] + 48'(mr[k]);
                    default: pr[k] <= pr[k];
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard / monitor: samples 1 time unit before each rising edge.
    always @(negedge clk) begin
        #4;
        cyc++;
        if (RST) begin
            mv_prev = 1'b0;
        end else begin
            if (s_valid && s_ready) last_acc = cyc;
            if (m_valid && !mv_prev) check("latency", 64'(cyc - last_acc), 64'(LAT + 1));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %0h, expected none", m_data);
                end else begin
                    check("result", 64'(m_data), 64'(exp_q.pop_front()));
                end
            end
            mv_prev = m_valid;
        end
    end

    task automatic send(input logic [17:0] a, input logic [17:0] b);
        int n;
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        n = 0;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_timeout", 64'(s_ready), 64'd1);
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset();
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_dsp_a", 64'(da[0]), 64'd0);
        check("rst_dsp_b", 64'(db[0]), 64'd0);
        check("rst_dsp_opmode", 64'(dop[0]), 64'd0);
        check("rst_dsp_ce", 64'(dce[0]), 64'd1);
        check("rst_dsp_rst", 64'(drst[0]), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        tab[0] = '{a: {18'd7, 18'd5, 18'd3, 18'd1}, b: {18'd8, 18'd6, 18'd4, 18'd2}, gap: 4'd0, exp: 48'd100};
        tab[1] = '{a: {18'd7, 18'd5, 18'd3, 18'd1}, b: {18'd8, 18'd6, 18'd4, 18'd2}, gap: 4'd3, exp: 48'd100};
        tab[2] = '{a: {4{18'd2}}, b: {4{18'd2}}, gap: 4'd0, exp: 48'd16};
        tab[3] = '{a: {4{18'h3FFFF}}, b: {4{18'h3FFFF}}, gap: 4'd1, exp: 48'h3F_FFE0_0004};

        RST = 1'b1;
        s_valid = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b1;
        s_valid8 = 1'b0; s_a8 = '0; s_b8 = '0; m_ready8 = 1'b1;
        repeat (3) @(negedge clk);
        check_reset();
        RST = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            exp_q.push_back(tab[v].exp);
            for (int j = 0; j < 4; j++) begin
                if (j > 0 && tab[v].gap != 0) begin
                    s_valid = 1'b0;
                    repeat (int'(tab[v].gap)) @(negedge clk);
                    if (tab[v].gap >= 2) check("bubble_opmode", 64'(dop[0]), 64'h08);
                end
                send(tab[v].a[j], tab[v].b[j]);
            end
            s_valid = 1'b0;
            wait_drain();
        end

        // Result held under back-pressure while the source presents the next pair.
        m_ready = 1'b0;
        exp_q.push_back(48'd100);
        for (int j = 0; j < 4; j++) send(tab[0].a[j], tab[0].b[j]);
        s_valid = 1'b1; s_a = 18'd9; s_b = 18'd9;
        n = 0;
        while (!m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("hold_wait", 64'(m_valid), 64'd1);
        repeat (10) begin
            @(negedge clk);
            check("hold_m_valid", 64'(m_valid), 64'd1);
            check("hold_m_data", 64'(m_data), 64'd100);
            check("hold_s_ready", 64'(s_ready), 64'd0);
        end
        m_ready = 1'b1;
        exp_q.push_back(48'd84);
        @(negedge clk);
        check("ready_after_hs", 64'(s_ready), 64'd1);
        check("valid_after_hs", 64'(m_valid), 64'd0);
        @(negedge clk);
        send(18'd1, 18'd1);
        check("first_opmode", 64'(dop[0]), 64'h01);
        send(18'd1, 18'd1);
        send(18'd1, 18'd1);
        s_valid = 1'b0;
        wait_drain();

        // Reset in the middle of a sum.
        send(18'd5, 18'd5);
        send(18'd5, 18'd5);
        s_a = 18'd7; s_b = 18'd7;
        RST = 1'b1;
        @(negedge clk);
        check_reset();
        RST = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        exp_q.push_back(48'd4);
        for (int j = 0; j < 4; j++) send(18'd1, 18'd1);
        s_valid = 1'b0;
        wait_drain();

        // Eight full-scale products on the 8-tap instance.
        s_valid8 = 1'b1; s_a8 = 18'h3FFFF; s_b8 = 18'h3FFFF;
        repeat (8) @(negedge clk);
        s_valid8 = 1'b0; s_a8 = '0; s_b8 = '0;
        n = 0;
        while (!m_valid8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("n8_valid", 64'(m_valid8), 64'd1);
        check("n8_full_scale", 64'(m_data8), 64'h7F_FFC0_0008);
        repeat (3) @(negedge clk);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
